// File: rtl/pal_pkg.sv
// Shared types and helpers for the palindrome generator: command mode and
// FSM state encodings, the default LFSR tap mask, and a width-generic bit
// reversal used to build the mirrored lower half of each word.
package pal_pkg;

    // Command mode carried on cmd_mode
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_BURST  = 1'b1
    } pal_mode_e;

    // Generator control state
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pal_state_e;

    // Widest half-word the bit reversal helper handles
    localparam int unsigned PAL_MAX_HALF = 64;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    // The full-width reversal parks the w interesting bits at the top, and
    // the shift brings them back down to bit 0.
    function automatic logic [PAL_MAX_HALF-1:0] bitrev(
        input logic [PAL_MAX_HALF-1:0] v,
        input int unsigned             w
    );
        logic [PAL_MAX_HALF-1:0] r;
        for (int i = 0; i < PAL_MAX_HALF; i++) begin
            r[i] = v[PAL_MAX_HALF-1-i];
        end
        return r >> (PAL_MAX_HALF - w);
    endfunction

endpackage

// File: rtl/pal_lfsr.sv
// HALF-bit right-shifting Galois LFSR. A load takes priority over an
// advance; an all-zero seed is replaced by 1 so the register never locks.
// The next-state value is exported so the caller can register the word
// built from it on the same edge the LFSR takes it.
module pal_lfsr
    import pal_pkg::*;
#(
    parameter int unsigned     HALF = 16,
    parameter logic [HALF-1:0] TAPS = LFSR_TAPS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [HALF-1:0] seed_i,
    input  logic            advance_i,
    output logic [HALF-1:0] lfsr_d_o
);

    logic [HALF-1:0] lfsr_q;
    logic [HALF-1:0] lfsr_d;
    logic [HALF-1:0] seed_eff;
    logic [HALF-1:0] step;

    // Zero-seed substitution and one Galois step from the current value
    always_comb begin
        seed_eff = (seed_i == '0) ? HALF'(1) : seed_i;
        step     = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    // Next-state select: load beats advance, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_eff;
        end else if (advance_i) begin
            lfsr_d = step;
        end
    end

    // LFSR register, reset to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= HALF'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_d_o = lfsr_d;

endmodule

// File: rtl/palindrome_generator.sv
// Stream source of bit-palindromes. A command either mirrors a supplied
// upper half once (direct) or walks the LFSR for cmd_count words (burst).
// Words leave on a valid/ready stream with registered outputs; cmd_ready
// and busy are decoded from the state register only.
module palindrome_generator
    import pal_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter int unsigned               CNT_W      = 8,
    parameter logic [DATA_WIDTH/2-1:0]   LFSR_TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_mode,
    input  logic [DATA_WIDTH/2-1:0] cmd_half,
    input  logic [CNT_W-1:0]        cmd_count,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned HALF = DATA_WIDTH / 2;

    pal_state_e            state_q, state_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  done_q, done_d;

    logic                  cmd_accept;
    logic                  cmd_is_burst;
    logic                  burst_start;
    logic                  out_hs;
    logic                  last_word;
    logic                  lfsr_advance;
    logic [HALF-1:0]       lfsr_d;

    // {h, bitrev(h)}: the word is symmetric about its centre
    function automatic logic [DATA_WIDTH-1:0] mirror(input logic [HALF-1:0] h);
        return {h, HALF'(bitrev(PAL_MAX_HALF'(h), HALF))};
    endfunction

    // Handshake and command decode shared by the FSM and the datapath
    always_comb begin
        cmd_accept   = (state_q == IDLE) && cmd_valid;
        cmd_is_burst = (cmd_mode == MODE_BURST);
        burst_start  = cmd_accept && cmd_is_burst && (cmd_count != '0);
        out_hs       = (state_q == EMIT) && dout_valid_q && dout_ready;
        last_word    = (remaining_q == CNT_W'(1));
        lfsr_advance = out_hs && !last_word;
    end

    pal_lfsr #(
        .HALF (HALF),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (burst_start),
        .seed_i    (cmd_half),
        .advance_i (lfsr_advance),
        .lfsr_d_o  (lfsr_d)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a zero-count burst never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept && (!cmd_is_burst || burst_start)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_hs && last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from state only
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == EMIT);
    end

    // Datapath next values: load on accept, step or retire on handshake,
    // otherwise hold so a stalled word stays put
    always_comb begin
        remaining_d  = remaining_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        if (cmd_accept) begin
            if (!cmd_is_burst) begin
                dout_d       = mirror(cmd_half);
                dout_valid_d = 1'b1;
                remaining_d  = CNT_W'(1);
            end else if (burst_start) begin
                dout_d       = mirror(lfsr_d);
                dout_valid_d = 1'b1;
                remaining_d  = cmd_count;
            end else begin
                done_d = 1'b1;
            end
        end else if (out_hs) begin
            if (last_word) begin
                dout_valid_d = 1'b0;
                done_d       = 1'b1;
                remaining_d  = '0;
            end else begin
                dout_d      = mirror(lfsr_d);
                remaining_d = remaining_q - CNT_W'(1);
            end
        end
    end

    // Datapath registers; reset abandons any burst without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            remaining_q  <= remaining_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_palindrome_generator.sv
// Bench for palindrome_generator: directed cases followed by randomized
// commands and output throttling checked against a queue-based model.
module tb_palindrome_generator;

    localparam int DW = 32;
    localparam int HW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [HW-1:0] cmd_half;
    logic [CW-1:0] cmd_count;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int            pending_done = 0;
    bit            prev_hold    = 1'b0;
    logic [DW-1:0] prev_word    = '0;

    palindrome_generator #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_half   (cmd_half),
        .cmd_count  (cmd_count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [HW-1:0] rev_half(input logic [HW-1:0] h);
        logic [HW-1:0] r;
        for (int i = 0; i < HW; i++) r[i] = h[HW-1-i];
        return r;
    endfunction

    function automatic logic [DW-1:0] pal_word(input logic [HW-1:0] h);
        return {h, rev_half(h)};
    endfunction

    function automatic logic [HW-1:0] lfsr_next(input logic [HW-1:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit is_pal(input logic [DW-1:0] w);
        for (int i = 0; i < DW / 2; i++) if (w[i] !== w[DW-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of the random phase: observe, drive, then score the
    // handshakes that the next rising edge will perform.
    task automatic rand_cycle(input bit allow_cmd);
        logic [HW-1:0] l;
        @(negedge clk);
        if (prev_hold) begin
            check("hold_valid", 64'(dout_valid), 64'd1);
            check("hold_data", 64'(dout), 64'(prev_word));
        end
        if (done) begin
            check("done_pending", 64'(pending_done > 0), 64'd1);
            check("done_words_drained", 64'(exp_q.size()), 64'd0);
            if (pending_done > 0) pending_done--;
        end
        cmd_valid  = allow_cmd && ($urandom_range(0, 3) == 0);
        cmd_mode   = 1'($urandom_range(0, 1));
        cmd_half   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        cmd_count  = ($urandom_range(0, 19) == 0) ? 8'hFF : CW'($urandom_range(0, 5));
        dout_ready = !allow_cmd || ($urandom_range(0, 3) != 0);
        if (dout_valid && dout_ready) begin
            check("word_queued", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("word_data", 64'(dout), 64'(exp_q.pop_front()));
            check("word_palindrome", 64'(is_pal(dout)), 64'd1);
        end
        prev_hold = dout_valid && !dout_ready;
        prev_word = dout;
        if (cmd_valid && cmd_ready) begin
            if (cmd_mode == 1'b0) begin
                exp_q.push_back(pal_word(cmd_half));
            end else begin
                l = (cmd_half == 16'h0000) ? 16'h0001 : cmd_half;
                for (int k = 0; k < int'(cmd_count); k++) begin
                    exp_q.push_back(pal_word(l));
                    l = lfsr_next(l);
                end
            end
            pending_done++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 1'b0;
        cmd_half   = '0;
        cmd_count  = '0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Direct word, consumed immediately
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_half = 16'hABCD; dout_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("d1_dout", 64'(dout), 64'hABCD_B3D5);
        check("d1_valid", 64'(dout_valid), 64'd1);
        check("d1_busy", 64'(busy), 64'd1);
        check("d1_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("d1_valid_off", 64'(dout_valid), 64'd0);
        check("d1_done", 64'(done), 64'd1);
        check("d1_cmd_ready_done", 64'(cmd_ready), 64'd1);
        check("d1_dout_kept", 64'(dout), 64'hABCD_B3D5);
        @(negedge clk);
        check("d1_done_once", 64'(done), 64'd0);

        // Direct word stalled three cycles, with a second command offered
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_half = 16'hFACE; dout_ready = 1'b0;
        @(negedge clk);
        cmd_half = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            check("d2_stall_dout", 64'(dout), 64'hFACE_735F);
            check("d2_stall_valid", 64'(dout_valid), 64'd1);
            check("d2_stall_busy", 64'(busy), 64'd1);
            check("d2_stall_cmd_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0; dout_ready = 1'b1;
        check("d2_last_dout", 64'(dout), 64'hFACE_735F);
        check("d2_last_valid", 64'(dout_valid), 64'd1);
        @(negedge clk);
        check("d2_valid_off", 64'(dout_valid), 64'd0);
        check("d2_done", 64'(done), 64'd1);
        @(negedge clk);
        check("d2_ignored_cmd", 64'(dout_valid), 64'd0);

        // Burst from seed 1, three words back to back
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_half = 16'h0001; cmd_count = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b3_w0", 64'(dout), 64'h0001_8000);
        check("b3_w0_valid", 64'(dout_valid), 64'd1);
        @(negedge clk);
        check("b3_w1", 64'(dout), 64'hB400_002D);
        check("b3_w1_valid", 64'(dout_valid), 64'd1);
        @(negedge clk);
        check("b3_w2", 64'(dout), 64'h5A00_005A);
        check("b3_w2_valid", 64'(dout_valid), 64'd1);
        @(negedge clk);
        check("b3_valid_off", 64'(dout_valid), 64'd0);
        check("b3_done", 64'(done), 64'd1);

        // Zero seed forced to 1; zero count emits nothing
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_half = 16'h0000; cmd_count = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("z_seed_word", 64'(dout), 64'h0001_8000);
        check("z_seed_valid", 64'(dout_valid), 64'd1);
        @(negedge clk);
        check("z_seed_done", 64'(done), 64'd1);
        cmd_valid = 1'b1; cmd_count = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("z_cnt_valid", 64'(dout_valid), 64'd0);
        check("z_cnt_done", 64'(done), 64'd1);
        check("z_cnt_busy", 64'(busy), 64'd0);
        check("z_cnt_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        check("z_cnt_done_once", 64'(done), 64'd0);

        // Reset in the middle of a burst
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_half = 16'h1234; cmd_count = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("r_w0", 64'(dout), 64'(pal_word(16'h1234)));
        @(negedge clk);
        check("r_w1", 64'(dout), 64'(pal_word(lfsr_next(16'h1234))));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("r_valid", 64'(dout_valid), 64'd0);
        check("r_busy", 64'(busy), 64'd0);
        check("r_done", 64'(done), 64'd0);
        check("r_cmd_ready", 64'(cmd_ready), 64'd1);
        check("r_dout", 64'(dout), 64'd0);
        @(negedge clk);
        check("r_no_done", 64'(done), 64'd0);

        // Randomized commands with throttled output
        prev_hold = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) rand_cycle(1'b1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (exp_q.size() == 0 && pending_done == 0 && !busy && !prev_hold) break;
            rand_cycle(1'b0);
        end
        check("drain_words", 64'(exp_q.size()), 64'd0);
        check("drain_done", 64'(pending_done), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
